// File: rtl/mmio_region_router.sv
// Routes host MMIO reads/writes by word index to one of NUM_REGIONS targets, rebasing the index per region.
// Latency: dev req appears 2 cycles after host req is presented; host ack 2 cycles after dev ack.
// Backpressure: host holds req until ack; targets stall via ack; TIMEOUT_CYCLES bounds each wait.
module mmio_region_router #(
  parameter int unsigned NUM_REGIONS    = 5,
  parameter int unsigned INDEX_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [NUM_REGIONS*INDEX_WIDTH-1:0] REGION_BASES =
    {INDEX_WIDTH'(1312), INDEX_WIDTH'(288), INDEX_WIDTH'(32), INDEX_WIDTH'(16), INDEX_WIDTH'(0)},
  parameter logic [NUM_REGIONS*INDEX_WIDTH-1:0] REGION_BOUNDS =
    {INDEX_WIDTH'(5408), INDEX_WIDTH'(1312), INDEX_WIDTH'(288), INDEX_WIDTH'(32), INDEX_WIDTH'(16)},
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              host_read_req,
  input  logic [INDEX_WIDTH-1:0]            host_read_index,
  output logic                              host_read_ack,
  output logic [DATA_WIDTH-1:0]             host_read_data,
  input  logic                              host_write_req,
  input  logic [INDEX_WIDTH-1:0]            host_write_index,
  input  logic [DATA_WIDTH-1:0]             host_write_data,
  output logic                              host_write_ack,
  output logic [NUM_REGIONS-1:0]            dev_read_req,
  output logic [NUM_REGIONS*INDEX_WIDTH-1:0] dev_read_index,
  input  logic [NUM_REGIONS-1:0]            dev_read_ack,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] dev_read_data,
  output logic [NUM_REGIONS-1:0]            dev_write_req,
  output logic [NUM_REGIONS*INDEX_WIDTH-1:0] dev_write_index,
  output logic [NUM_REGIONS*DATA_WIDTH-1:0] dev_write_data,
  input  logic [NUM_REGIONS-1:0]            dev_write_ack,
  output logic [15:0]                       error_count
);

  // Last ISSUE cycle (counted while the dev req is visible) before giving up on the target.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESPOND = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // One-hot region match; the lowest matching region wins when ranges overlap.
  function automatic logic [NUM_REGIONS-1:0] region_decode(input logic [INDEX_WIDTH-1:0] idx);
    logic [NUM_REGIONS-1:0] oh;
    logic                   found;
    oh    = '0;
    found = 1'b0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (!found &&
          idx >= REGION_BASES[r*INDEX_WIDTH +: INDEX_WIDTH] &&
          idx <  REGION_BOUNDS[r*INDEX_WIDTH +: INDEX_WIDTH]) begin
        oh[r] = 1'b1;
        found = 1'b1;
      end
    end
    return oh;
  endfunction

  // Base index of the region selected by a one-hot vector (0 when none).
  function automatic logic [INDEX_WIDTH-1:0] region_base(input logic [NUM_REGIONS-1:0] oh);
    logic [INDEX_WIDTH-1:0] b;
    b = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (oh[r]) b = b | REGION_BASES[r*INDEX_WIDTH +: INDEX_WIDTH];
    end
    return b;
  endfunction

  // ---------------- read channel state ----------------
  state_t                 rd_state_q, rd_state_d;
  logic [NUM_REGIONS-1:0] rd_sel_q, rd_sel_d;
  logic [INDEX_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [NUM_REGIONS-1:0] rd_dev_req_q, rd_dev_req_d;
  logic [15:0]            rd_cnt_q, rd_cnt_d;
  logic                   rd_ack_q, rd_ack_d;
  logic                   rd_err;
  logic                   rd_hit;
  logic                   rd_expire;
  logic [NUM_REGIONS-1:0] rd_dec;
  logic [DATA_WIDTH-1:0]  rd_sel_data;

  // ---------------- write channel state ----------------
  state_t                 wr_state_q, wr_state_d;
  logic [NUM_REGIONS-1:0] wr_sel_q, wr_sel_d;
  logic [INDEX_WIDTH-1:0] wr_idx_q, wr_idx_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [NUM_REGIONS-1:0] wr_dev_req_q, wr_dev_req_d;
  logic [15:0]            wr_cnt_q, wr_cnt_d;
  logic                   wr_ack_q, wr_ack_d;
  logic                   wr_err;
  logic                   wr_hit;
  logic                   wr_expire;
  logic [NUM_REGIONS-1:0] wr_dec;

  logic [15:0] err_q, err_d;
  logic [16:0] err_sum;

  assign rd_dec = region_decode(host_read_index);
  assign wr_dec = region_decode(host_write_index);

  // An ack only counts from the target currently being driven, so stray or late acks are dropped.
  assign rd_hit    = |(dev_read_ack & rd_dev_req_q);
  assign wr_hit    = |(dev_write_ack & wr_dev_req_q);
  assign rd_expire = (|rd_dev_req_q) && (rd_cnt_q == TO_LAST);
  assign wr_expire = (|wr_dev_req_q) && (wr_cnt_q == TO_LAST);

  // Pick the read data of the selected target.
  always_comb begin
    rd_sel_data = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (rd_sel_q[r]) rd_sel_data = rd_sel_data | dev_read_data[r*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Read FSM next state: decode, issue, wait for ack or timeout, respond, wait for req release.
  always_comb begin
    rd_state_d   = rd_state_q;
    rd_sel_d     = rd_sel_q;
    rd_idx_d     = rd_idx_q;
    rd_data_d    = rd_data_q;
    rd_cnt_d     = rd_cnt_q;
    rd_dev_req_d = '0;
    rd_ack_d     = 1'b0;
    rd_err       = 1'b0;
    case (rd_state_q)
      ST_IDLE: begin
        if (host_read_req) begin
          rd_cnt_d = '0;
          if (|rd_dec) begin
            rd_sel_d   = rd_dec;
            rd_idx_d   = host_read_index - region_base(rd_dec);
            rd_state_d = ST_ISSUE;
          end else begin
            rd_data_d  = '0;
            rd_err     = 1'b1;
            rd_state_d = ST_RESPOND;
          end
        end
      end
      ST_ISSUE: begin
        if (rd_hit) begin
          rd_data_d  = rd_sel_data;
          rd_state_d = ST_RESPOND;
        end else if (rd_expire) begin
          rd_data_d  = '0;
          rd_err     = 1'b1;
          rd_state_d = ST_RESPOND;
        end else begin
          rd_dev_req_d = rd_sel_q;
          if (|rd_dev_req_q) rd_cnt_d = rd_cnt_q + 16'd1;
        end
      end
      ST_RESPOND: begin
        rd_ack_d   = 1'b1;
        rd_state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!host_read_req) rd_state_d = ST_IDLE;
      end
      default: rd_state_d = ST_IDLE;
    endcase
  end

  // Write FSM next state: same sequence as reads, with the write data latched at decode.
  always_comb begin
    wr_state_d   = wr_state_q;
    wr_sel_d     = wr_sel_q;
    wr_idx_d     = wr_idx_q;
    wr_data_d    = wr_data_q;
    wr_cnt_d     = wr_cnt_q;
    wr_dev_req_d = '0;
    wr_ack_d     = 1'b0;
    wr_err       = 1'b0;
    case (wr_state_q)
      ST_IDLE: begin
        if (host_write_req) begin
          wr_cnt_d = '0;
          if (|wr_dec) begin
            wr_sel_d   = wr_dec;
            wr_idx_d   = host_write_index - region_base(wr_dec);
            wr_data_d  = host_write_data;
            wr_state_d = ST_ISSUE;
          end else begin
            wr_err     = 1'b1;
            wr_state_d = ST_RESPOND;
          end
        end
      end
      ST_ISSUE: begin
        if (wr_hit) begin
          wr_state_d = ST_RESPOND;
        end else if (wr_expire) begin
          wr_err     = 1'b1;
          wr_state_d = ST_RESPOND;
        end else begin
          wr_dev_req_d = wr_sel_q;
          if (|wr_dev_req_q) wr_cnt_d = wr_cnt_q + 16'd1;
        end
      end
      ST_RESPOND: begin
        wr_ack_d   = 1'b1;
        wr_state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!host_write_req) wr_state_d = ST_IDLE;
      end
      default: wr_state_d = ST_IDLE;
    endcase
  end

  // Errors from both channels in one cycle add together; the counter sticks at all-ones.
  always_comb begin
    err_sum = 17'(err_q) + 17'(rd_err) + 17'(wr_err);
    err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // State registers for both channels and the error counter; reset abandons any transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q   <= ST_IDLE;
      rd_sel_q     <= '0;
      rd_idx_q     <= '0;
      rd_data_q    <= '0;
      rd_dev_req_q <= '0;
      rd_cnt_q     <= '0;
      rd_ack_q     <= 1'b0;
      wr_state_q   <= ST_IDLE;
      wr_sel_q     <= '0;
      wr_idx_q     <= '0;
      wr_data_q    <= '0;
      wr_dev_req_q <= '0;
      wr_cnt_q     <= '0;
      wr_ack_q     <= 1'b0;
      err_q        <= '0;
    end else begin
      rd_state_q   <= rd_state_d;
      rd_sel_q     <= rd_sel_d;
      rd_idx_q     <= rd_idx_d;
      rd_data_q    <= rd_data_d;
      rd_dev_req_q <= rd_dev_req_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_ack_q     <= rd_ack_d;
      wr_state_q   <= wr_state_d;
      wr_sel_q     <= wr_sel_d;
      wr_idx_q     <= wr_idx_d;
      wr_data_q    <= wr_data_d;
      wr_dev_req_q <= wr_dev_req_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_ack_q     <= wr_ack_d;
      err_q        <= err_d;
    end
  end

  // Only the target being requested sees a non-zero index/data.
  for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_dev
    assign dev_read_index[r*INDEX_WIDTH +: INDEX_WIDTH]  = rd_dev_req_q[r] ? rd_idx_q  : '0;
    assign dev_write_index[r*INDEX_WIDTH +: INDEX_WIDTH] = wr_dev_req_q[r] ? wr_idx_q  : '0;
    assign dev_write_data[r*DATA_WIDTH +: DATA_WIDTH]    = wr_dev_req_q[r] ? wr_data_q : '0;
  end

  assign dev_read_req   = rd_dev_req_q;
  assign dev_write_req  = wr_dev_req_q;
  assign host_read_ack  = rd_ack_q;
  assign host_read_data = rd_ack_q ? rd_data_q : '0;
  assign host_write_ack = wr_ack_q;
  assign error_count    = err_q;

endmodule

// File: tb/tb_mmio_region_router.sv
// Randomized bench for mmio_region_router: scripted host/target stimulus, per-cycle expectation tables.
// Expected outputs are derived from region tables and the documented cycle timing, then compared every cycle.
// All waits are on the bench's own cycle counter, so the run always terminates.
module tb_mmio_region_router;
  localparam int NR   = 5;
  localparam int IW   = 32;
  localparam int DW   = 32;
  localparam int T    = 4;
  localparam int MAXC = 4000;

  localparam logic [31:0] BASE  [NR] = '{32'd0, 32'd16, 32'd32, 32'd288, 32'd1312};
  localparam logic [31:0] BOUND [NR] = '{32'd16, 32'd32, 32'd288, 32'd1312, 32'd5408};

  logic              clock;
  logic              reset;
  logic              host_read_req;
  logic [IW-1:0]     host_read_index;
  logic              host_read_ack;
  logic [DW-1:0]     host_read_data;
  logic              host_write_req;
  logic [IW-1:0]     host_write_index;
  logic [DW-1:0]     host_write_data;
  logic              host_write_ack;
  logic [NR-1:0]     dev_read_req;
  logic [NR*IW-1:0]  dev_read_index;
  logic [NR-1:0]     dev_read_ack;
  logic [NR*DW-1:0]  dev_read_data;
  logic [NR-1:0]     dev_write_req;
  logic [NR*IW-1:0]  dev_write_index;
  logic [NR*DW-1:0]  dev_write_data;
  logic [NR-1:0]     dev_write_ack;
  logic [15:0]       error_count;

  mmio_region_router #(
    .NUM_REGIONS(NR), .INDEX_WIDTH(IW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock), .reset(reset),
    .host_read_req(host_read_req), .host_read_index(host_read_index),
    .host_read_ack(host_read_ack), .host_read_data(host_read_data),
    .host_write_req(host_write_req), .host_write_index(host_write_index),
    .host_write_data(host_write_data), .host_write_ack(host_write_ack),
    .dev_read_req(dev_read_req), .dev_read_index(dev_read_index),
    .dev_read_ack(dev_read_ack), .dev_read_data(dev_read_data),
    .dev_write_req(dev_write_req), .dev_write_index(dev_write_index),
    .dev_write_data(dev_write_data), .dev_write_ack(dev_write_ack),
    .error_count(error_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected outputs per cycle (cycle n = interval after the n-th rising edge).
  logic [NR-1:0] e_rreq [MAXC];
  logic [IW-1:0] e_ridx [MAXC];
  logic          e_rack [MAXC];
  logic [DW-1:0] e_rdat [MAXC];
  logic [NR-1:0] e_wreq [MAXC];
  logic [IW-1:0] e_widx [MAXC];
  logic [DW-1:0] e_wdat [MAXC];
  logic          e_wack [MAXC];
  int            e_rinc [MAXC];
  int            e_winc [MAXC];
  bit            e_rst  [MAXC];

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  function automatic bit model_decode(input logic [31:0] idx, output int region, output logic [31:0] loc);
    region = -1;
    loc    = '0;
    for (int r = 0; r < NR; r++) begin
      if (region < 0 && idx >= BASE[r] && idx < BOUND[r]) begin
        region = r;
        loc    = idx - BASE[r];
      end
    end
    return region >= 0;
  endfunction

  function automatic logic [31:0] rand_idx();
    int k;
    int r;
    k = $urandom_range(0, 9);
    r = $urandom_range(0, NR - 1);
    if (k < 5)       return BASE[r] + $urandom_range(0, BOUND[r] - BASE[r] - 1);
    else if (k == 5) return BASE[r];
    else if (k == 6) return BOUND[r] - 1;
    else if (k == 7) return BOUND[r];
    else if (k == 8) return $urandom_range(5408, 100000);
    else             return $urandom;
  endfunction

  task automatic wait_neg(input int n);
    do @(negedge clock); while (cyc < n);
  endtask

  // One host transaction on a channel, starting in the current cycle with that channel idle.
  // lat = cycles of visible dev req before the target acks; lat >= T means the target never acks.
  task automatic run_txn(input bit wr, input logic [31:0] idx, input logic [31:0] wdat,
                         input logic [31:0] rsp, input int lat, input int hold);
    int s, a, r, last;
    logic [31:0] loc;
    bit mapped, acked;
    logic [NR-1:0] nz;
    s      = cyc;
    mapped = model_decode(idx, r, loc);
    acked  = mapped && (lat < T);
    if (!mapped)    a = s;
    else if (acked) a = s + 2 + lat;
    else            a = s + 1 + T;
    if (mapped) begin
      for (int c = s + 2; c <= a; c++) begin
        if (wr) begin
          e_wreq[c] = NR'(1) << r; e_widx[c] = loc; e_wdat[c] = wdat;
        end else begin
          e_rreq[c] = NR'(1) << r; e_ridx[c] = loc;
        end
      end
    end
    if (wr) begin
      e_wack[a + 2] = 1'b1;
      e_winc[a + 1] = acked ? 0 : 1;
    end else begin
      e_rack[a + 2] = 1'b1;
      e_rdat[a + 2] = acked ? rsp : 32'd0;
      e_rinc[a + 1] = acked ? 0 : 1;
    end
    last = a + 2 + hold;
    while (cyc <= last + 1) begin
      nz = NR'($urandom) & NR'($urandom);
      if (mapped) nz[r] = 1'b0;
      if (acked && cyc == a) nz[r] = 1'b1;
      if (mapped && !acked && cyc == a + 1) nz[r] = 1'b1;
      if (wr) begin
        host_write_req   = (cyc <= last);
        host_write_index = (cyc == s) ? idx  : $urandom;
        host_write_data  = (cyc == s) ? wdat : $urandom;
        dev_write_ack    = nz;
      end else begin
        host_read_req   = (cyc <= last);
        host_read_index = (cyc == s) ? idx : $urandom;
        dev_read_ack    = nz;
        for (int k = 0; k < NR; k++) dev_read_data[k*DW +: DW] = $urandom;
        if (acked && cyc == a) dev_read_data[r*DW +: DW] = rsp;
      end
      @(posedge clock); #1;
    end
    if (wr) dev_write_ack = '0; else dev_read_ack = '0;
  endtask

  // Per-cycle comparison of every output against the expectation tables.
  int err_m = 0;
  always @(negedge clock) begin
    if (cyc >= 1 && cyc < MAXC) begin
      logic [NR*IW-1:0] x_ridx, x_widx;
      logic [NR*DW-1:0] x_wdat;
      int c;
      c = cyc;
      if (e_rst[c]) err_m = 0;
      else begin
        err_m = err_m + e_rinc[c] + e_winc[c];
        if (err_m > 65535) err_m = 65535;
      end
      for (int r = 0; r < NR; r++) begin
        x_ridx[r*IW +: IW] = e_rreq[c][r] ? e_ridx[c] : '0;
        x_widx[r*IW +: IW] = e_wreq[c][r] ? e_widx[c] : '0;
        x_wdat[r*DW +: DW] = e_wreq[c][r] ? e_wdat[c] : '0;
      end
      chk("dev_read_req",    dev_read_req,    e_rreq[c]);
      chk("dev_read_index",  dev_read_index,  x_ridx);
      chk("host_read_ack",   host_read_ack,   e_rack[c]);
      chk("host_read_data",  host_read_data,  e_rdat[c]);
      chk("dev_write_req",   dev_write_req,   e_wreq[c]);
      chk("dev_write_index", dev_write_index, x_widx);
      chk("dev_write_data",  dev_write_data,  x_wdat);
      chk("host_write_ack",  host_write_ack,  e_wack[c]);
      chk("error_count",     error_count,     err_m[15:0]);
    end
  end

  initial begin
    int s, mr;
    logic [31:0] ml;
    bit mok;
    for (int c = 0; c < MAXC; c++) begin
      e_rreq[c] = '0; e_ridx[c] = '0; e_rack[c] = 1'b0; e_rdat[c] = '0;
      e_wreq[c] = '0; e_widx[c] = '0; e_wdat[c] = '0; e_wack[c] = 1'b0;
      e_rinc[c] = 0;  e_winc[c] = 0;  e_rst[c] = 1'b0;
    end
    reset = 1'b1;
    host_read_req = 1'b0;  host_read_index = '0;
    host_write_req = 1'b0; host_write_index = '0; host_write_data = '0;
    dev_read_ack = '0; dev_read_data = '0; dev_write_ack = '0;

    // Hand-computed decode results pin the reference model.
    mok = model_decode(32'd20, mr, ml);   chk("m20_region", mr, 1);  chk("m20_local", ml, 4);
    mok = model_decode(32'd1400, mr, ml); chk("m1400_region", mr, 4); chk("m1400_local", ml, 88);
    mok = model_decode(32'd16, mr, ml);   chk("m16_local", ml, 0);   chk("m16_region", mr, 1);
    mok = model_decode(32'd5407, mr, ml); chk("m5407_local", ml, 4095);
    mok = model_decode(32'd6000, mr, ml); chk("m6000_mapped", mok, 0);
    mok = model_decode(32'd5408, mr, ml); chk("m5408_mapped", mok, 0);

    e_rst[1] = 1'b1; e_rst[2] = 1'b1; e_rst[3] = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Read index 20 -> target 1 local 4, target acks with 0xCAFE after 3 cycles.
    s = cyc;
    fork
      run_txn(1'b0, 32'd20, 32'd0, 32'hCAFE, 3, 0);
      begin
        wait_neg(s + 2);
        chk("r20_dev_req", dev_read_req, 5'b00010);
        chk("r20_dev_index1", dev_read_index[1*IW +: IW], 4);
        wait_neg(s + 7);
        chk("r20_host_ack", host_read_ack, 1);
        chk("r20_host_data", host_read_data, 32'hCAFE);
      end
    join

    // Write index 1400 data 0x55 -> target 4 local 88.
    s = cyc;
    fork
      run_txn(1'b1, 32'd1400, 32'h55, 32'd0, 1, 1);
      begin
        wait_neg(s + 2);
        chk("w1400_dev_req", dev_write_req, 5'b10000);
        chk("w1400_dev_index4", dev_write_index[4*IW +: IW], 88);
        chk("w1400_dev_data4", dev_write_data[4*DW +: DW], 32'h55);
        wait_neg(s + 5);
        chk("w1400_host_ack", host_write_ack, 1);
      end
    join

    // Unmapped read: ack with 0 two cycles later, one error.
    s = cyc;
    fork
      run_txn(1'b0, 32'd6000, 32'd0, 32'd0, 0, 0);
      begin
        wait_neg(s + 2);
        chk("r6000_ack", host_read_ack, 1);
        chk("r6000_data", host_read_data, 0);
        chk("r6000_err", error_count, 1);
      end
    join

    // Target 2 never acks: dev req held T cycles, then ack with 0 and a second error.
    s = cyc;
    fork
      run_txn(1'b0, 32'd40, 32'd0, 32'd0, 99, 1);
      begin
        wait_neg(s + 1 + T);
        chk("to_req_last", dev_read_req, 5'b00100);
        wait_neg(s + 2 + T);
        chk("to_req_drop", dev_read_req, 5'b00000);
        wait_neg(s + 3 + T);
        chk("to_ack", host_read_ack, 1);
        chk("to_err", error_count, 2);
      end
    join

    // Concurrent read of region 0 and write of region 3.
    fork
      run_txn(1'b0, 32'd5,   32'd0,        32'h1234_5678, 2, 0);
      run_txn(1'b1, 32'd500, 32'hA5A5_0001, 32'd0,        0, 2);
    join
    // Concurrent unmapped read and write: the counter steps by 2 in one cycle.
    fork
      run_txn(1'b0, 32'd7000, 32'd0, 32'd0, 0, 0);
      run_txn(1'b1, 32'd9999, 32'd1, 32'd0, 0, 0);
    join

    // Randomized traffic on both channels.
    fork
      for (int n = 0; n < 40; n++) begin
        run_txn(1'b0, rand_idx(), $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 2));
        repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      end
      for (int n = 0; n < 40; n++) begin
        run_txn(1'b1, rand_idx(), $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 2));
        repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      end
    join

    // Reset while a read to region 3 is in ISSUE.
    s = cyc;
    host_read_req = 1'b1;
    host_read_index = 32'd300;
    e_rreq[s + 2] = 5'b01000; e_ridx[s + 2] = 32'd12;
    e_rreq[s + 3] = 5'b01000; e_ridx[s + 3] = 32'd12;
    e_rst[s + 4] = 1'b1;
    while (cyc < s + 3) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    host_read_req = 1'b0;
    wait_neg(s + 4);
    chk("rst_dev_req", dev_read_req, 0);
    chk("rst_host_ack", host_read_ack, 0);
    chk("rst_err", error_count, 0);
    repeat (6) @(posedge clock);
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
